// File: rtl/tdm_pkg.sv
// Shared types and constants for the four-channel TDM demultiplexer.
package tdm_pkg;

    localparam int unsigned NUM_CH = 4;

    typedef enum logic {
        IDLE,
        RUN
    } state_t;

    typedef logic [1:0] slot_t;

    localparam slot_t LAST_SLOT = slot_t'(NUM_CH - 1);

endpackage

// File: rtl/tdm_frame_buf.sv
// Staging registers for one frame plus the published output registers.
// Commit copies the whole stage at once so outputs never show a mixed frame.
module tdm_frame_buf
    import tdm_pkg::*;
#(
    parameter int W = 8
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic [W-1:0] din,
    input  logic         wr_en,
    input  slot_t        wr_slot,
    input  logic         commit,
    output logic [W-1:0] y0,
    output logic [W-1:0] y1,
    output logic [W-1:0] y2,
    output logic [W-1:0] y3,
    output logic         frame_valid
);

    logic [W-1:0] stage [NUM_CH];

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            stage       <= '{default: '0};
            y0          <= '0;
            y1          <= '0;
            y2          <= '0;
            y3          <= '0;
            frame_valid <= 1'b0;
        end else begin
            frame_valid <= commit;
            if (wr_en) begin
                stage[wr_slot] <= din;
            end
            // Commit coincides with the slot-3 write, so ch3 comes straight from din.
            if (commit) begin
                y0 <= stage[0];
                y1 <= stage[1];
                y2 <= stage[2];
                y3 <= din;
            end
        end
    end

endmodule

// File: rtl/tdm_demux4.sv
// Receive end of a 4:1 TDM link: sof alignment, slot FSM, framing errors.
// Optional even-parity frame rejection is enabled with TDM_DEMUX_PARITY_EN.
module tdm_demux4
    import tdm_pkg::*;
#(
    parameter int W = 8
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic [W-1:0] din,
    input  logic         din_valid,
    input  logic         sof,
`ifdef TDM_DEMUX_PARITY_EN
    input  logic         din_par,
`endif
    output logic [W-1:0] y0,
    output logic [W-1:0] y1,
    output logic [W-1:0] y2,
    output logic [W-1:0] y3,
    output logic         frame_valid,
    output logic         sync_err
`ifdef TDM_DEMUX_PARITY_EN
    ,
    output logic         par_err
`endif
);

    state_t state;
    slot_t  slot;
    logic   wr_en;
    slot_t  wr_slot;
    logic   frame_done;
    logic   commit;

    always_comb begin
        wr_en      = 1'b0;
        wr_slot    = '0;
        frame_done = 1'b0;
        if (din_valid) begin
            if (sof) begin
                wr_en = 1'b1;
            end else if (state == RUN) begin
                wr_en      = 1'b1;
                wr_slot    = slot;
                frame_done = (slot == LAST_SLOT);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state    <= IDLE;
            slot     <= '0;
            sync_err <= 1'b0;
        end else begin
            sync_err <= 1'b0;
            if (din_valid) begin
                if (sof) begin
                    // A sof while collecting aborts the partial frame and restarts.
                    sync_err <= (state == RUN);
                    state    <= RUN;
                    slot     <= slot_t'(1);
                end else if (state == IDLE) begin
                    sync_err <= 1'b1;
                end else if (slot == LAST_SLOT) begin
                    state <= IDLE;
                    slot  <= '0;
                end else begin
                    slot <= slot + slot_t'(1);
                end
            end
        end
    end

`ifdef TDM_DEMUX_PARITY_EN
    logic bad;
    logic samp_bad;

    assign samp_bad = ^{din, din_par};
    assign commit   = frame_done & ~(bad | samp_bad);

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            bad     <= 1'b0;
            par_err <= 1'b0;
        end else begin
            par_err <= 1'b0;
            if (din_valid) begin
                if (sof) begin
                    bad <= samp_bad;
                end else if (state == RUN) begin
                    if (slot == LAST_SLOT) begin
                        bad     <= 1'b0;
                        par_err <= bad | samp_bad;
                    end else begin
                        bad <= bad | samp_bad;
                    end
                end
            end
        end
    end
`else
    assign commit = frame_done;
`endif

    tdm_frame_buf #(
        .W(W)
    ) u_frame_buf (
        .clk        (clk),
        .rst_n      (rst_n),
        .din        (din),
        .wr_en      (wr_en),
        .wr_slot    (wr_slot),
        .commit     (commit),
        .y0         (y0),
        .y1         (y1),
        .y2         (y2),
        .y3         (y3),
        .frame_valid(frame_valid)
    );

endmodule

// File: doc/tdm_demux4.md
# tdm_demux4

Four-channel time-division demultiplexer: the receive end of a 4:1 multiplexed link. Accepts one sample per valid cycle from a serial TDM stream, aligns to a start-of-frame marker, assembles four slots into a staging buffer, and publishes all four channel outputs together with a one-cycle frame strobe. Sits behind the mux datapath in the verification bench and in any link that serialises four channels onto one bus.

## Interface
- W, 8, sample width in bits per channel.
- clk  input  1  rising-edge clock.
- rst_n  input  1  reset, synchronous, active-low.
- din  input  W  TDM sample; slot order ch0, ch1, ch2, ch3.
- din_valid  input  1  din carries a sample this cycle.
- sof  input  1  qualifies din as slot 0 (ch0) of a new frame; ignored unless din_valid.
- din_par  input  1  even-parity bit for din (present only with TDM_DEMUX_PARITY_EN).
- y0, y1, y2, y3  output  W each  registered channel outputs, last complete frame.
- frame_valid  output  1  one-cycle pulse: y0..y3 updated this cycle.
- sync_err  output  1  one-cycle pulse: framing violation detected.
- par_err  output  1  one-cycle pulse: frame discarded on parity (present only with TDM_DEMUX_PARITY_EN).

## Operation
- FSM states: IDLE (hunting for sof), RUN (collecting slots 1..3). 2-bit slot counter, valid in RUN only.
- IDLE, din_valid & sof: din -> stage[0], slot=1, go RUN.
- IDLE, din_valid & !sof: sample dropped, sync_err pulse, stay IDLE.
- RUN, din_valid & !sof: din -> stage[slot]. If slot==3: commit, go IDLE; else slot+1.
- RUN, din_valid & sof: partial frame aborted (no commit), sync_err pulse; din -> stage[0], slot=1, stay RUN.
- din_valid low: no state change in either state; gaps of any length allowed mid-frame.
- Commit: y0..y3 <= stage[0..3] simultaneously, frame_valid pulse. Outputs never show a partially-updated frame.
- Back-to-back frames (sof on cycle immediately after slot 3) fully supported, zero dead cycles.

## Timing
- Reset (rst_n low at clk edge): state IDLE, slot=0, stage cleared, y0..y3=0, frame_valid=0, sync_err=0, par_err=0. Reset mid-frame discards the partial frame.
- Latency: slot-3 sample accepted at edge N -> y0..y3 and frame_valid visible after edge N+1 registered... i.e. asserted in cycle following acceptance, one cycle.
- sync_err, par_err asserted in the cycle after the offending sample, one cycle wide.
- Throughput: one frame per 4 valid cycles.
- Outputs hold value indefinitely between commits.

## Configuration
- TDM_DEMUX_PARITY_EN defined: din_par and par_err ports exist; each accepted sample checked (^{din,din_par} must be 0); any mismatch in a frame sets a sticky bad flag, cleared at sof. At slot 3 a bad frame is not committed: y0..y3 unchanged, frame_valid low, par_err pulses instead. Aborted frames clear the flag without par_err.
- Undefined: no parity ports or logic; every completed frame commits.

## Structure
- Package tdm_pkg: NUM_CH=4, state enum (IDLE, RUN), slot index typedef (2-bit).
- One sub-module: tdm_frame_buf (stage registers plus output registers, write-enable by slot, commit strobe); FSM and error logic stay in tdm_demux4.

## Test plan
- Reset then sof+0x11, 0x22, 0x33, 0x44 on consecutive valid cycles -> one cycle later y0..y3=0x11/0x22/0x33/0x44, frame_valid single pulse.
- Frame with 3 idle cycles between each slot (0xA0..0xA3) -> same commit, frame_valid once after 0xA3 only.
- Valid sample 0x55 without sof in IDLE -> sync_err pulse, outputs unchanged; following aligned frame commits normally.
- sof+0x01, 0x02, then sof+0x10, 0x20, 0x30, 0x40 -> sync_err at second sof, only 0x10..0x40 committed, one frame_valid.
- rst_n low after slot 2, then full frame 0xB0..0xB3 -> outputs 0 during reset, then 0xB0..0xB3.
- With TDM_DEMUX_PARITY_EN: slot 2 sent with wrong parity -> par_err pulse, no frame_valid, y* keep previous frame; next good frame commits.
